// File: rtl/spi_byte_receiver.sv
// spi_byte_receiver: SPI peripheral-side serial-to-parallel word receiver.
//   i_clock     : serial bit clock, all state changes on its rising edge
//   i_reset_n   : asynchronous active-low reset
//   i_dataIn    : serial data, sampled on rising edge of i_clock
//   i_select    : active-low select, 0 = transfer in progress
//   o_dataByte  : last completed word, held until the next one completes
//   o_byteValid : one-cycle pulse when o_dataByte is updated
//   o_busy      : high while a partial word is being assembled
module spi_byte_receiver #(
    parameter int DATA_WIDTH = 8,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_dataIn,
    input  logic                  i_select,
    output logic [DATA_WIDTH-1:0] o_dataByte,
    output logic                  o_byteValid,
    output logic                  o_busy
);
    localparam int CW = $clog2(DATA_WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, data_q, data_d, shifted;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_cur;
    logic                  valid_q, valid_d, busy_q, busy_d, last;
    always_comb begin
        // A word always starts from bit 0 when leaving IDLE.
        cnt_cur = (state_q == IDLE) ? '0 : cnt_q;
        shifted = LSB_FIRST ? {i_dataIn, shift_q[DATA_WIDTH-1:1]}
                            : {shift_q[DATA_WIDTH-2:0], i_dataIn};
        last    = (cnt_cur == CW'(DATA_WIDTH - 1));
        state_d = i_select ? IDLE : SHIFT;
        shift_d = i_select ? shift_q : shifted;
        // Select is checked before the last bit, so a deselect on that edge aborts.
        cnt_d   = (i_select || last) ? '0 : cnt_cur + CW'(1);
        valid_d = !i_select && last;
        data_d  = valid_d ? shifted : data_q;
        busy_d  = (cnt_d != '0);
    end
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end
    assign o_dataByte  = data_q;
    assign o_byteValid = valid_q;
    assign o_busy      = busy_q;
endmodule

// File: tb/tb_spi_byte_receiver.sv
// tb_spi_byte_receiver: self-checking bench for both bit orders of spi_byte_receiver.
module tb_spi_byte_receiver;
    localparam int W = 8;
    logic         clk = 1'b0;
    logic         i_reset_n = 1'b0;
    logic         i_select = 1'b1;
    logic         i_dataIn = 1'b0;
    logic [W-1:0] dl, dm;
    logic         vl, vm, bl, bm;
    logic [W-1:0] exp_l = '0, exp_m = '0;
    logic         exp_v = 1'b0, exp_b = 1'b0;
    bit           bits[$];
    int           checks = 0;
    int           errs = 0;
    always #5 clk = ~clk;
    spi_byte_receiver #(.DATA_WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .i_clock(clk), .i_reset_n(i_reset_n), .i_dataIn(i_dataIn), .i_select(i_select),
        .o_dataByte(dl), .o_byteValid(vl), .o_busy(bl)
    );
    spi_byte_receiver #(.DATA_WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .i_clock(clk), .i_reset_n(i_reset_n), .i_dataIn(i_dataIn), .i_select(i_select),
        .o_dataByte(dm), .o_byteValid(vm), .o_busy(bm)
    );
    function automatic logic [2*W+3:0] got();
        return {dl, dm, vl, vm, bl, bm};
    endfunction
    function automatic logic [2*W+3:0] want();
        return {exp_l, exp_m, exp_v, exp_v, exp_b, exp_b};
    endfunction
    // Drive one bit period and advance the reference model: the collected bits of
    // the current word form the word directly, bit i landing at i or W-1-i.
    task automatic drive(input logic sel, input logic din);
        @(negedge clk);
        i_select = sel;
        i_dataIn = din;
        @(posedge clk);
        #1;
        exp_v = 1'b0;
        if (sel) bits.delete();
        else begin
            bits.push_back(din);
            if (bits.size() == W) begin
                exp_l = '0;
                exp_m = '0;
                for (int i = 0; i < W; i++) begin
                    exp_l[i]       = bits[i];
                    exp_m[W-1-i]   = bits[i];
                end
                exp_v = 1'b1;
                bits.delete();
            end
        end
        exp_b = (bits.size() != 0);
    endtask
    task automatic model_reset();
        bits.delete();
        exp_l = '0;
        exp_m = '0;
        exp_v = 1'b0;
        exp_b = 1'b0;
    endtask
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (got() !== want()) begin
            errs++;
            $display("FAIL reset: got %h want %h", got(), want());
        end
        @(negedge clk);
        i_reset_n = 1'b1;
    endtask
    task automatic test_single();
        logic [W-1:0] w = 8'h11;
        for (int i = 0; i < W; i++) begin
            drive(1'b0, w[i]);
            checks++;
            if (got() !== want()) begin
                errs++;
                $display("FAIL single bit%0d: got %h want %h", i, got(), want());
            end
            checks++;
            if (vl !== (i == W - 1)) begin
                errs++;
                $display("FAIL single pulse bit%0d: got %b want %b", i, vl, i == W - 1);
            end
        end
        drive(1'b1, 1'b0);
        checks++;
        if (dl !== 8'h11 || vl !== 1'b0) begin
            errs++;
            $display("FAIL single word: got %h/%b want 11/0", dl, vl);
        end
    endtask
    task automatic test_back_to_back();
        logic [2*W-1:0] s = {8'h3C, 8'hA5};
        logic [2*W-1:0] pulses = '0;
        for (int i = 0; i < 2 * W; i++) begin
            drive(1'b0, s[i]);
            pulses[i] = vl;
            checks++;
            if (got() !== want()) begin
                errs++;
                $display("FAIL b2b bit%0d: got %h want %h", i, got(), want());
            end
            if (i == W - 1) begin
                checks++;
                if (dl !== 8'hA5) begin
                    errs++;
                    $display("FAIL b2b first: got %h want a5", dl);
                end
            end
        end
        checks++;
        if (dl !== 8'h3C || pulses !== 16'h8080) begin
            errs++;
            $display("FAIL b2b second: got %h pulses %h want 3c pulses 8080", dl, pulses);
        end
        drive(1'b1, 1'b0);
    endtask
    task automatic test_abort();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1);
            checks++;
            if (got() !== want()) begin
                errs++;
                $display("FAIL abort bit%0d: got %h want %h", i, got(), want());
            end
        end
        drive(1'b1, 1'b1);
        checks++;
        if (dl !== 8'h3C || vl !== 1'b0 || bl !== 1'b0) begin
            errs++;
            $display("FAIL abort hold: got %h/%b/%b want 3c/0/0", dl, vl, bl);
        end
        for (int i = 0; i < W; i++) begin
            logic [W-1:0] w = 8'h42;
            drive(1'b0, w[i]);
            checks++;
            if (got() !== want()) begin
                errs++;
                $display("FAIL abort refill bit%0d: got %h want %h", i, got(), want());
            end
        end
        checks++;
        if (dl !== 8'h42) begin
            errs++;
            $display("FAIL abort word: got %h want 42", dl);
        end
        drive(1'b1, 1'b0);
    endtask
    task automatic test_bit_order();
        for (int i = 0; i < W; i++) drive(1'b0, i == 0);
        checks++;
        if (dl !== 8'h01 || dm !== 8'h80 || vl !== 1'b1 || vm !== 1'b1) begin
            errs++;
            $display("FAIL bit order: got lsb %h msb %h want 01 80", dl, dm);
        end
        drive(1'b1, 1'b0);
    endtask
    task automatic test_idle();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, i[0]);
            checks++;
            if (got() !== want() || dl !== 8'h01 || bl !== 1'b0) begin
                errs++;
                $display("FAIL idle cyc%0d: got %h want %h", i, got(), want());
            end
        end
    endtask
    task automatic test_abort_last();
        for (int i = 0; i < W - 1; i++) drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        checks++;
        if (got() !== want() || vl !== 1'b0 || dl !== 8'h01) begin
            errs++;
            $display("FAIL abort last: got %h want %h", got(), want());
        end
        drive(1'b0, 1'b0);
        checks++;
        if (bl !== 1'b1 || got() !== want()) begin
            errs++;
            $display("FAIL fresh start: got %h want %h", got(), want());
        end
        drive(1'b1, 1'b0);
    endtask
    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) == 0, 1'($urandom));
            checks++;
            if (got() !== want()) begin
                errs++;
                $display("FAIL random cyc%0d: got %h want %h", i, got(), want());
            end
        end
        drive(1'b1, 1'b0);
    endtask
    task automatic test_reset_mid_word();
        for (int i = 0; i < W; i++) drive(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
        #2;
        i_reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (got() !== want()) begin
            errs++;
            $display("FAIL async reset: got %h want %h", got(), want());
        end
        @(negedge clk);
        i_select = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (got() !== want()) begin
            errs++;
            $display("FAIL reset hold: got %h want %h", got(), want());
        end
        @(negedge clk);
        i_reset_n = 1'b1;
        for (int i = 0; i < W; i++) begin
            logic [W-1:0] w = 8'hC3;
            drive(1'b0, w[i]);
        end
        checks++;
        if (dl !== 8'hC3 || got() !== want()) begin
            errs++;
            $display("FAIL post reset: got %h want %h", got(), want());
        end
    endtask
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_bit_order();
        test_idle();
        test_abort_last();
        test_random();
        test_reset_mid_word();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/spi_byte_receiver.md
Name: spi_byte_receiver

Overview:
- Serial-to-parallel SPI receive block (peripheral side).
- Shifts one data bit per rising edge of i_clock while the active-low select is asserted.
- Presents each completed word on o_dataByte, held until the next word completes.
- Sits between an SPI bus input and byte-oriented downstream logic; i_clock is the serial bit clock.

Parameters:
- DATA_WIDTH, 8, bits per word; valid range 2..32.
- LSB_FIRST, 1, 1 = first received bit lands in bit 0; 0 = first received bit lands in bit DATA_WIDTH-1.

Ports:
- i_clock  input  1  serial bit clock; all state updates on its rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_dataIn  input  1  serial data; sampled on the rising edge of i_clock.
- i_select  input  1  active-low select; 0 = transfer in progress.
- o_dataByte  output  DATA_WIDTH  last completed word.
- o_byteValid  output  1  one-cycle pulse when o_dataByte is updated.
- o_busy  output  1  high while a partial word is being assembled (bit count nonzero).

Behaviour:
- Reset (i_reset_n=0, asynchronous, any time):
  - Shift register, bit counter, o_dataByte all 0.
  - o_byteValid=0, o_busy=0.
  - Released synchronously on the next rising edge.
- Idle: with i_select=1 at a rising edge, the shift register is not updated, the bit counter clears to 0, and o_byteValid=0. o_dataByte holds its value.
- Receive: at each rising edge with i_select=0:
  - LSB_FIRST=1: shift register shifts right, i_dataIn enters bit DATA_WIDTH-1.
  - LSB_FIRST=0: shift register shifts left, i_dataIn enters bit 0.
  - Bit counter increments.
- Word complete: on the edge sampling bit number DATA_WIDTH (counter at DATA_WIDTH-1):
  - o_dataByte loads the assembled word, including the bit sampled on that same edge.
  - o_byteValid=1 for exactly that one cycle.
  - Counter wraps to 0.
  - Latency: o_dataByte valid immediately after the edge that samples the last bit.
- Back-to-back: with select held low, the next edge starts the next word with no gap cycles. o_byteValid pulses once per word.
- Abort: select deasserted with 0 < count < DATA_WIDTH:
  - Partial word is discarded and the counter clears.
  - o_dataByte is unchanged and no o_byteValid pulse occurs.
  - Reselecting starts a fresh word at bit 0.
- Select deasserted on the same edge the last bit would be sampled: the bit is not sampled (select is checked first), so the word is aborted.
- o_busy = (bit counter != 0), registered.
- State machine:
  - IDLE -> SHIFT on a sampled edge with select low.
  - SHIFT -> IDLE on select high.
  - SHIFT -> SHIFT on word completion while select stays low.
- Reset mid-word: everything clears and no pulse is generated.
- Bench drive rule: change i_dataIn/i_select away from the rising edge (e.g. on the falling edge). Setup and hold are relative to the rising edge.

Test Plan:
- Reset: assert i_reset_n=0 mid-run -> o_dataByte=0, o_byteValid=0, o_busy=0 immediately, without waiting for a clock edge.
- Single byte, LSB_FIRST=1: select low, send 0x11 LSB first (1,0,0,0,1,0,0,0), select high -> o_dataByte=0x11, exactly one o_byteValid pulse, on the 8th sampled edge.
- Back-to-back: select held low for 16 bits, sending 0xA5 then 0x3C -> o_dataByte=0xA5 then 0x3C, two pulses 8 cycles apart.
- Abort: select low for 5 bits of 0xFF, then select high, then a full byte 0x42 -> no pulse after the 5 bits, o_dataByte stays at its prior value, then becomes 0x42.
- Bit order: LSB_FIRST=0, send bits 1,0,0,0,0,0,0,0 -> o_dataByte=0x80; the same stream with LSB_FIRST=1 -> 0x01.
- Idle hold: i_select=1 with toggling i_dataIn for 20 cycles -> o_dataByte unchanged, o_byteValid=0, o_busy=0.
